rv32v_elem_sequencer: RTL and testbench

- Sits directly downstream of the OPI/OPM decode stage in the rv32v pipeline.
- Accepts one decoded vector instruction: vexec_t bundle, legality, mask-disable flag, vm bit, vl and vstart.
- Breaks the instruction into beats of NUM_LANES elements and issues one micro-op per beat to the vector functional units over a valid/ready handshake.
- Computes a per-lane enable for each beat from vstart, vl and the v0 mask, and reports completion and illegal instructions.

---
 rtl/rv32v_elem_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_rv32v_elem_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_elem_sequencer.sv
// Element sequencer: splits one decoded vector instruction into NUM_LANES-wide beats with per-lane enables.
// First beat one cycle after accept; beat fields hold while uop_ready is low; done pulses one cycle after the last beat.
package rv32v_seq_pkg;

  typedef enum logic [2:0] {
    VFU_ALU = 3'd0,
    VFU_MUL = 3'd1,
    VFU_DIV = 3'd2,
    VFU_RED = 3'd3,
    VFU_MSK = 3'd4,
    VFU_PRM = 3'd5
  } vfu_e;

  typedef struct packed {
    vfu_e       fu;
    logic [5:0] funct6;
    logic [2:0] funct3;
    logic [4:0] vd;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [1:0] vsew;
  } vexec_t;

endpackage

module rv32v_elem_sequencer
  import rv32v_seq_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 128,
  parameter int VL_W      = $clog2(VLEN) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic                 dec_legal,
  input  vexec_t               dec_vexec,
  input  logic                 dec_disable_mask,
  input  logic                 dec_vm,
  input  logic [VL_W-1:0]      dec_vl,
  input  logic [VL_W-1:0]      dec_vstart,
  input  logic [NUM_LANES-1:0] mask_bits,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output vexec_t               uop_vexec,
  output logic [VL_W-1:0]      uop_eidx,
  output logic [NUM_LANES-1:0] uop_lane_en,
  output logic                 uop_first,
  output logic                 uop_last,
  output logic                 done,
  output logic                 illegal,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [VL_W-1:0] ALIGN_MASK = ~VL_W'(NUM_LANES - 1);
  localparam logic [VL_W-1:0] LANES_V    = VL_W'(NUM_LANES);

  state_e          state_q, state_d;
  vexec_t          vexec_q, vexec_d;
  logic            dmask_q, dmask_d;
  logic            vm_q, vm_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [VL_W-1:0] vstart_q, vstart_d;
  logic [VL_W-1:0] eidx_q, eidx_d;
  logic            first_q, first_d;
  logic            illegal_q, illegal_d;

  logic                 in_issue;
  logic                 clr_fields;
  logic [VL_W-1:0]      eidx_next;
  logic                 beat_last;
  logic [NUM_LANES-1:0] lane_en;

  assign in_issue  = (state_q == ISSUE);
  assign eidx_next = eidx_q + LANES_V;
  assign beat_last = (eidx_next >= vl_q);

  // A lane is live only inside [vstart, vl) and when the mask (if honoured) allows it.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [VL_W-1:0] lane_idx;
    assign lane_idx   = eidx_q + VL_W'(g);
    assign lane_en[g] = (lane_idx >= vstart_q) && (lane_idx < vl_q) &&
                        (dmask_q || vm_q || mask_bits[g]);
  end

  always_comb begin
    state_d    = state_q;
    vexec_d    = vexec_q;
    dmask_d    = dmask_q;
    vm_d       = vm_q;
    vl_d       = vl_q;
    vstart_d   = vstart_q;
    eidx_d     = eidx_q;
    first_d    = first_q;
    illegal_d  = 1'b0;
    clr_fields = 1'b0;

    case (state_q)
      IDLE: begin
        if (dec_valid) begin
          if (!dec_legal) begin
            illegal_d = 1'b1;
          end else begin
            vexec_d  = dec_vexec;
            dmask_d  = dec_disable_mask;
            vm_d     = dec_vm;
            vl_d     = dec_vl;
            vstart_d = dec_vstart;
            eidx_d   = dec_vstart & ALIGN_MASK;
            first_d  = 1'b1;
            state_d  = (dec_vstart >= dec_vl) ? DONE : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (uop_ready) begin
          eidx_d  = eidx_next;
          first_d = 1'b0;
          if (beat_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        clr_fields = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        clr_fields = 1'b1;
      end
    endcase

    // Flush beats every transition, including an accept or reject in IDLE.
    if (flush) begin
      state_d    = IDLE;
      illegal_d  = 1'b0;
      clr_fields = 1'b1;
    end

    if (clr_fields) begin
      vexec_d  = '0;
      dmask_d  = 1'b0;
      vm_d     = 1'b0;
      vl_d     = '0;
      vstart_d = '0;
      eidx_d   = '0;
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      vexec_q   <= '0;
      dmask_q   <= 1'b0;
      vm_q      <= 1'b0;
      vl_q      <= '0;
      vstart_q  <= '0;
      eidx_q    <= '0;
      first_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vexec_q   <= vexec_d;
      dmask_q   <= dmask_d;
      vm_q      <= vm_d;
      vl_q      <= vl_d;
      vstart_q  <= vstart_d;
      eidx_q    <= eidx_d;
      first_q   <= first_d;
      illegal_q <= illegal_d;
    end
  end

  assign dec_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign illegal     = illegal_q;
  assign uop_valid   = in_issue;
  assign uop_vexec   = vexec_q;
  assign uop_eidx    = eidx_q;
  assign uop_lane_en = in_issue ? lane_en : '0;
  assign uop_first   = in_issue & first_q;
  assign uop_last    = in_issue & beat_last;

endmodule

// File: tb/tb_rv32v_elem_sequencer.sv
// Scoreboard bench for rv32v_elem_sequencer: expected beats queued at stimulus, popped on each uop handshake.
module tb_rv32v_elem_sequencer;
  import rv32v_seq_pkg::*;

  localparam int NL   = 4;
  localparam int VLEN = 128;
  localparam int VL_W = $clog2(VLEN) + 1;

  typedef struct packed {
    logic [VL_W-1:0] eidx;
    logic [NL-1:0]   en;
    logic            first;
    logic            last;
  } beat_t;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            flush = 1'b0;
  logic            dec_valid = 1'b0;
  logic            dec_ready;
  logic            dec_legal = 1'b0;
  vexec_t          dec_vexec = '0;
  logic            dec_disable_mask = 1'b0;
  logic            dec_vm = 1'b0;
  logic [VL_W-1:0] dec_vl = '0;
  logic [VL_W-1:0] dec_vstart = '0;
  logic [NL-1:0]   mask_bits;
  logic            uop_valid;
  logic            uop_ready;
  vexec_t          uop_vexec;
  logic [VL_W-1:0] uop_eidx;
  logic [NL-1:0]   uop_lane_en;
  logic            uop_first;
  logic            uop_last;
  logic            done;
  logic            illegal;
  logic            busy;

  rv32v_elem_sequencer #(.NUM_LANES(NL), .VLEN(VLEN), .VL_W(VL_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_legal(dec_legal),
    .dec_vexec(dec_vexec), .dec_disable_mask(dec_disable_mask), .dec_vm(dec_vm),
    .dec_vl(dec_vl), .dec_vstart(dec_vstart), .mask_bits(mask_bits),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_vexec(uop_vexec),
    .uop_eidx(uop_eidx), .uop_lane_en(uop_lane_en), .uop_first(uop_first),
    .uop_last(uop_last), .done(done), .illegal(illegal), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // v0 model: combinational read indexed by uop_eidx
  logic [VLEN-1:0] v0 = '0;
  always_comb begin
    mask_bits = '0;
    for (int i = 0; i < NL; i++) begin
      if (int'(uop_eidx) + i < VLEN) mask_bits[i] = v0[int'(uop_eidx) + i];
    end
  end

  // Functional-unit backpressure: stall the beat at stall_eidx until stall_cyc reaches stall_limit
  int              cyc = 0;
  int              stall_cyc = 0;
  int              stall_limit = 0;
  bit              stall_on = 1'b0;
  logic [VL_W-1:0] stall_eidx = '0;
  assign uop_ready = !(stall_on && uop_valid && (uop_eidx == stall_eidx) && (stall_cyc < stall_limit));

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (uop_valid && !uop_ready) stall_cyc <= stall_cyc + 1;
  end

  beat_t           exp_q[$];
  vexec_t          cur_vexec = '0;
  int              hs_cnt = 0;
  int              last_hs_cyc = 0;
  bit              prev_stall = 1'b0;
  logic [VL_W-1:0] held_eidx = '0;
  logic [NL-1:0]   held_en = '0;
  logic            held_first = 1'b0;
  logic            held_last = 1'b0;

  always @(negedge CLK) begin
    if (uop_valid && uop_ready) begin
      beat_t e;
      hs_cnt++;
      last_hs_cyc = cyc;
      check_val("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("beat_eidx", 32'(uop_eidx), 32'(e.eidx));
        check_val("beat_lane_en", 32'(uop_lane_en), 32'(e.en));
        check_val("beat_first", 32'(uop_first), 32'(e.first));
        check_val("beat_last", 32'(uop_last), 32'(e.last));
        check_val("beat_vexec", 32'(uop_vexec), 32'(cur_vexec));
      end
    end
    if (uop_valid && !uop_ready) begin
      if (prev_stall) begin
        check_val("hold_eidx", 32'(uop_eidx), 32'(held_eidx));
        check_val("hold_lane_en", 32'(uop_lane_en), 32'(held_en));
        check_val("hold_first", 32'(uop_first), 32'(held_first));
        check_val("hold_last", 32'(uop_last), 32'(held_last));
      end
      held_eidx  = uop_eidx;
      held_en    = uop_lane_en;
      held_first = uop_first;
      held_last  = uop_last;
      prev_stall = 1'b1;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic void push_beat(input int eidx, input logic [NL-1:0] en, input bit f, input bit l);
    beat_t b;
    b.eidx  = VL_W'(eidx);
    b.en    = en;
    b.first = f;
    b.last  = l;
    exp_q.push_back(b);
  endfunction

  function automatic vexec_t mk_vexec(input vfu_e fu, input logic [5:0] f6);
    vexec_t v;
    v.fu     = fu;
    v.funct6 = f6;
    v.funct3 = 3'b000;
    v.vd     = 5'd4;
    v.vs1    = 5'd8;
    v.vs2    = 5'd12;
    v.vsew   = 2'd2;
    return v;
  endfunction

  task automatic send(input vexec_t vx, input bit legal, input bit dmask, input bit vm,
                      input int vl, input int vstart, input bit with_flush);
    @(negedge CLK); #2;
    check_val("dec_ready_pre", 32'(dec_ready), 32'd1);
    cur_vexec        = vx;
    dec_vexec        = vx;
    dec_legal        = legal;
    dec_disable_mask = dmask;
    dec_vm           = vm;
    dec_vl           = VL_W'(vl);
    dec_vstart       = VL_W'(vstart);
    dec_valid        = 1'b1;
    flush            = with_flush;
    @(posedge CLK); #1;
    dec_valid = 1'b0;
    dec_legal = 1'b0;
    flush     = 1'b0;
  endtask

  // Fixed 30-cycle observation window after an accept; counts pulses and checks done timing.
  task automatic run_window(input string tag, input int exp_done, input int exp_ill,
                            input int hs_base, input int exp_hs);
    int nd = 0;
    int ni = 0;
    int nv = 0;
    bit prev_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK); #2;
      if (prev_done) check_val({tag, "_rdy_after_done"}, 32'(dec_ready), 32'd1);
      prev_done = done;
      if (done) begin
        nd++;
        check_val({tag, "_done_uop_valid"}, 32'(uop_valid), 32'd0);
        check_val({tag, "_done_dec_ready"}, 32'(dec_ready), 32'd0);
        if (exp_hs > 0) check_val({tag, "_done_latency"}, 32'(cyc - last_hs_cyc), 32'd1);
      end
      if (illegal) begin
        ni++;
        check_val({tag, "_ill_dec_ready"}, 32'(dec_ready), 32'd1);
      end
      if (uop_valid) nv++;
    end
    check_val({tag, "_done_count"}, 32'(nd), 32'(exp_done));
    check_val({tag, "_illegal_count"}, 32'(ni), 32'(exp_ill));
    check_val({tag, "_handshakes"}, 32'(hs_cnt - hs_base), 32'(exp_hs));
    check_val({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    if (exp_hs == 0) check_val({tag, "_no_uop"}, 32'(nv), 32'd0);
  endtask

  task automatic wait_beat(input string tag, input logic [VL_W-1:0] eidx);
    bit found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge CLK); #2;
      if (uop_valid && uop_eidx == eidx) found = 1'b1;
    end
    check_val({tag, "_reached_beat"}, 32'(found), 32'd1);
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_uop_valid"}, 32'(uop_valid), 32'd0);
    check_val({tag, "_uop_first"}, 32'(uop_first), 32'd0);
    check_val({tag, "_uop_last"}, 32'(uop_last), 32'd0);
    check_val({tag, "_uop_eidx"}, 32'(uop_eidx), 32'd0);
    check_val({tag, "_uop_lane_en"}, 32'(uop_lane_en), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_illegal"}, 32'(illegal), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_dec_ready"}, 32'(dec_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vexec_t vadd, vmerge, vred;
    int     base;
    vadd   = mk_vexec(VFU_ALU, 6'b000000);
    vmerge = mk_vexec(VFU_ALU, 6'b010111);
    vred   = mk_vexec(VFU_RED, 6'b000000);

    #2;
    check_quiet("rst_hold");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK); #2;
    check_quiet("rst_release");

    // Unmasked three-beat instruction
    base = hs_cnt;
    push_beat(0, 4'b1111, 1, 0);
    push_beat(4, 4'b1111, 0, 0);
    push_beat(8, 4'b0011, 0, 1);
    send(vadd, 1, 0, 1, 10, 0, 0);
    run_window("unmasked", 1, 0, base, 3);

    // v0 mask honoured, then ignored for merge class
    v0 = 128'hA;
    base = hs_cnt;
    push_beat(0, 4'b1010, 1, 1);
    send(vadd, 1, 0, 0, 4, 0, 0);
    run_window("masked", 1, 0, base, 1);

    base = hs_cnt;
    push_beat(0, 4'b1111, 1, 1);
    send(vmerge, 1, 1, 0, 4, 0, 0);
    run_window("merge", 1, 0, base, 1);
    v0 = '0;

    // vstart inside the vector, then vstart == vl
    base = hs_cnt;
    push_beat(4, 4'b1100, 1, 0);
    push_beat(8, 4'b0011, 0, 1);
    send(vadd, 1, 0, 1, 10, 6, 0);
    run_window("vstart6", 1, 0, base, 2);

    base = hs_cnt;
    send(vadd, 1, 0, 1, 10, 10, 0);
    run_window("vstart_eq_vl", 1, 0, base, 0);

    base = hs_cnt;
    send(vadd, 1, 0, 1, 0, 0, 0);
    run_window("vl_zero", 1, 0, base, 0);

    // Illegal instruction
    base = hs_cnt;
    send(vadd, 0, 0, 1, 8, 0, 0);
    run_window("illegal", 0, 1, base, 0);

    // Backpressure on beat 1 of a reduction, vl=12
    base = hs_cnt;
    stall_eidx  = VL_W'(4);
    stall_limit = stall_cyc + 3;
    stall_on    = 1'b1;
    push_beat(0, 4'b1111, 1, 0);
    push_beat(4, 4'b1111, 0, 0);
    push_beat(8, 4'b1111, 0, 1);
    send(vred, 1, 0, 1, 12, 0, 0);
    run_window("bp", 1, 0, base, 3);
    check_val("bp_stall_cycles", 32'(stall_cyc - (stall_limit - 3)), 32'd3);
    stall_on = 1'b0;

    // Flush during beat 1
    base = hs_cnt;
    stall_eidx  = VL_W'(4);
    stall_limit = stall_cyc + 1000;
    stall_on    = 1'b1;
    push_beat(0, 4'b1111, 1, 0);
    send(vadd, 1, 0, 1, 12, 0, 0);
    wait_beat("flush", VL_W'(4));
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    check_quiet("flush_after");
    run_window("flush", 0, 0, base, 1);
    stall_on = 1'b0;

    // Flush coincident with an illegal accept drops it silently
    base = hs_cnt;
    send(vadd, 0, 0, 1, 8, 0, 1);
    run_window("flush_idle", 0, 0, base, 0);

    // Asynchronous reset mid-issue
    base = hs_cnt;
    stall_eidx  = VL_W'(4);
    stall_limit = stall_cyc + 1000;
    stall_on    = 1'b1;
    push_beat(0, 4'b1111, 1, 0);
    send(vadd, 1, 0, 1, 12, 0, 0);
    wait_beat("areset", VL_W'(4));
    RST = 1'b1;
    #1;
    check_quiet("areset_async");
    @(negedge CLK);
    RST = 1'b0;
    stall_on = 1'b0;
    run_window("areset", 0, 0, base, 1);

    // Recovery after reset: single partial beat
    base = hs_cnt;
    push_beat(0, 4'b0111, 1, 1);
    send(vadd, 1, 0, 1, 3, 0, 0);
    run_window("recover", 1, 0, base, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
